// File: rtl/wb_retire_unit_pkg.sv
// Shared types and constants for the write-back / retire slice.
package wb_retire_unit_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int IIDW_DEF = 8;

  typedef logic [XLEN_DEF-1:0]         UIntX;
  typedef logic [XLEN_DEF-1:0]         Addr;
  typedef logic [IIDW_DEF-1:0]         IId;
  typedef logic [$clog2(NREG_DEF)-1:0] RegAddr;

  // Fill value of general registers out of reset, and first expected instruction id.
  localparam UIntX ADDR_MAX = {XLEN_DEF{1'b1}};
  localparam IId   IID_X    = {IIDW_DEF{1'b0}};

endpackage

// File: rtl/wb_instid_checker.sv
// Instruction-id ordering checker: valid channels must carry consecutive ids in ascending
// channel order. Only instantiated when WB_INSTID_CHECK_EN is defined.
module wb_instid_checker
  import wb_retire_unit_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int IIDW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    valid,
  input  logic [NCH*IIDW-1:0] inst_id,
  output logic              order_err
);

  logic [IIDW-1:0] expected_id_q, expected_id_d;
  logic            order_err_q, order_err_d;
  logic [IIDW-1:0] exp_s, bad_exp_s, bad_act_s;
  logic [31:0]     bad_ch_s;
  logic            mismatch_s;
  logic            hit_s;

  // Walk the valid channels oldest-first, recording the first id that breaks the sequence.
  always_comb begin
    exp_s      = expected_id_q;
    mismatch_s = 1'b0;
    hit_s      = 1'b0;
    bad_ch_s   = 32'd0;
    bad_exp_s  = {IIDW{1'b0}};
    bad_act_s  = {IIDW{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      hit_s      = valid[c] && !mismatch_s && (inst_id[c*IIDW +: IIDW] != exp_s);
      bad_ch_s   = hit_s ? 32'(c) : bad_ch_s;
      bad_exp_s  = hit_s ? exp_s : bad_exp_s;
      bad_act_s  = hit_s ? inst_id[c*IIDW +: IIDW] : bad_act_s;
      mismatch_s = mismatch_s | hit_s;
      exp_s      = valid[c] ? (exp_s + IIDW'(1'b1)) : exp_s;
    end
    expected_id_d = exp_s;
    order_err_d   = order_err_q | mismatch_s;
  end

  // Expected-id and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_id_q <= IIDW'(IID_X);
      order_err_q   <= 1'b0;
    end else begin
      expected_id_q <= expected_id_d;
      order_err_q   <= order_err_d;
    end
  end

`ifndef SYNTHESIS
  // Report only the first ordering error after reset.
  always_ff @(posedge clk) begin
    if (rst_n && mismatch_s && !order_err_q) begin
      $display("wb_instid_checker: order error on channel %0d, expected id %0d, got id %0d",
               bad_ch_s, bad_exp_s, bad_act_s);
    end
  end
`endif

  assign order_err = order_err_q;

endmodule

// File: rtl/wb_retire_unit.sv
// N-channel write-back / retire stage: register file commit, cycle and retire counters, sticky halt.
// Optional instruction-id ordering checker enabled by defining WB_INSTID_CHECK_EN.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              NCH      = 2,
  parameter int              IIDW     = 8,
  parameter logic [XLEN-1:0] INIT_SP  = 32'h00007500,
  parameter logic [63:0]     END_INST = 64'd0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCH-1:0]                valid,
  input  logic [NCH-1:0]                rf_wen,
  input  logic [NCH*$clog2(NREG)-1:0]   reg_addr,
  input  logic [NCH*XLEN-1:0]           wdata,
  input  logic [NCH*IIDW-1:0]           inst_id,
  output logic [NREG*XLEN-1:0]          regfile,
  output logic [63:0]                   inst_count,
  output logic [63:0]                   clock_count,
  output logic                          halt
`ifdef WB_INSTID_CHECK_EN
  ,
  output logic                          order_err
`endif
);

  localparam int RAW = $clog2(NREG);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [63:0]     inst_count_q, inst_count_d;
  logic [63:0]     clock_count_q, clock_count_d;
  logic            halt_q, halt_d;
  logic [63:0]     retired_s;
  logic [NCH-1:0]  we_s;

  function automatic logic [XLEN-1:0] reset_val(input int r);
    if (r == 0) begin
      return {XLEN{1'b0}};
    end else if (r == 2) begin
      return INIT_SP;
    end else begin
      return {XLEN{1'b1}};
    end
  endfunction

  // Commit writes oldest-to-youngest so the youngest colliding channel wins; x0 never matches.
  always_comb begin
    retired_s = 64'd0;
    for (int c = 0; c < NCH; c++) begin
      we_s[c]   = valid[c] & rf_wen[c] & (reg_addr[c*RAW +: RAW] != {RAW{1'b0}});
      retired_s = retired_s + 64'(valid[c]);
    end
    for (int r = 0; r < NREG; r++) begin
      rf_d[r] = rf_q[r];
      for (int c = 0; c < NCH; c++) begin
        rf_d[r] = (we_s[c] && (32'(reg_addr[c*RAW +: RAW]) == 32'(r)))
                  ? wdata[c*XLEN +: XLEN] : rf_d[r];
      end
    end
    inst_count_d  = inst_count_q + retired_s;
    clock_count_d = clock_count_q + 64'd1;
    halt_d        = halt_q | ((END_INST != 64'd0) && (inst_count_d >= END_INST));
  end

  // Architectural state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= reset_val(r);
      end
      inst_count_q  <= 64'd0;
      clock_count_q <= 64'd0;
      halt_q        <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= rf_d[r];
      end
      inst_count_q  <= inst_count_d;
      clock_count_q <= clock_count_d;
      halt_q        <= halt_d;
    end
  end

  // Flatten the register array onto the output bus.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regfile[r*XLEN +: XLEN] = rf_q[r];
    end
  end

  assign inst_count  = inst_count_q;
  assign clock_count = clock_count_q;
  assign halt        = halt_q;

`ifdef WB_INSTID_CHECK_EN
  wb_instid_checker #(
    .NCH  (NCH),
    .IIDW (IIDW)
  ) u_instid_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .inst_id   (inst_id),
    .order_err (order_err)
  );
`else
  logic unused_inst_id_s;
  assign unused_inst_id_s = ^inst_id;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Self-checking bench for wb_retire_unit: vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the retire rules.
module tb_wb_retire_unit;
  import wb_retire_unit_pkg::*;

  localparam int          NCH   = 2;
  localparam logic [63:0] END_N = 64'd5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   valid, rf_wen;
  logic [9:0]   reg_addr;
  logic [63:0]  wdata;
  logic [15:0]  inst_id;
  logic [1023:0] regfile, regfile0;
  logic [63:0]  inst_count, clock_count, ic0, cc0;
  logic         halt, halt0;
`ifdef WB_INSTID_CHECK_EN
  logic         order_err, order_err0;
`endif

  always #5 clk = ~clk;

  wb_retire_unit #(.END_INST(END_N)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .rf_wen(rf_wen), .reg_addr(reg_addr),
    .wdata(wdata), .inst_id(inst_id), .regfile(regfile), .inst_count(inst_count),
    .clock_count(clock_count), .halt(halt)
`ifdef WB_INSTID_CHECK_EN
    , .order_err(order_err)
`endif
  );

  // Same design with the halt disabled.
  wb_retire_unit #(.END_INST(64'd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .rf_wen(rf_wen), .reg_addr(reg_addr),
    .wdata(wdata), .inst_id(inst_id), .regfile(regfile0), .inst_count(ic0),
    .clock_count(cc0), .halt(halt0)
`ifdef WB_INSTID_CHECK_EN
    , .order_err(order_err0)
`endif
  );

  // Behavioural model
  logic [31:0]     m_rf [32];
  longint unsigned m_ic, m_cc;
  bit              m_halt;
  logic [7:0]      m_id;
  int              n_chk = 0;
  int              n_fail = 0;

  typedef struct {
    logic [1:0]  v, we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [4:0]  r1;
    logic [31:0] e1;
    logic [4:0]  r2;
    logic [31:0] e2;
    logic [63:0] eic;
    logic        eh;
  } vec_t;
  vec_t tbl [6];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = (r == 0) ? 32'h0 : ((r == 2) ? 32'h00007500 : ADDR_MAX);
    end
    m_ic = 0; m_cc = 0; m_halt = 1'b0; m_id = 8'd0;
  endfunction

  // Retire in program order: a later channel simply overwrites an earlier one.
  function automatic void m_retire();
    for (int c = 0; c < NCH; c++) begin
      if (valid[c]) begin
        m_ic++;
        m_id++;
        if (rf_wen[c] && reg_addr[c*5 +: 5] != 5'd0) m_rf[reg_addr[c*5 +: 5]] = wdata[c*32 +: 32];
      end
    end
    m_cc++;
    if (m_ic >= END_N) m_halt = 1'b1;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    valid = v; rf_wen = we; reg_addr = {a1, a0}; wdata = {d1, d0};
    inst_id = {m_id + (v[0] ? 8'd1 : 8'd0), m_id};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) m_retire();
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("%s x%0d", tag, r), {32'h0, regfile[r*32 +: 32]}, {32'h0, m_rf[r]});
      check($sformatf("%s nohalt x%0d", tag, r), {32'h0, regfile0[r*32 +: 32]}, {32'h0, m_rf[r]});
    end
    check({tag, " inst_count"}, inst_count, m_ic);
    check({tag, " clock_count"}, clock_count, m_cc);
    check({tag, " halt"}, {63'd0, halt}, {63'd0, m_halt});
    check({tag, " nohalt inst_count"}, ic0, m_ic);
    check({tag, " nohalt clock_count"}, cc0, m_cc);
    check({tag, " nohalt halt"}, {63'd0, halt0}, 64'd0);
`ifdef WB_INSTID_CHECK_EN
    check({tag, " order_err"}, {63'd0, order_err}, 64'd0);
`endif
  endtask

  initial begin
    tbl[0] = '{2'b11, 2'b11, 5'd5,  5'd6,  32'h11, 32'h22, 5'd5,  32'h11,       5'd6,  32'h22,       64'd2,  1'b0};
    tbl[1] = '{2'b11, 2'b11, 5'd7,  5'd7,  32'hAA, 32'hBB, 5'd7,  32'hBB,       5'd5,  32'h11,       64'd4,  1'b0};
    tbl[2] = '{2'b01, 2'b01, 5'd0,  5'd3,  32'h55, 32'h0,  5'd0,  32'h0,        5'd3,  32'hFFFFFFFF, 64'd5,  1'b1};
    tbl[3] = '{2'b10, 2'b11, 5'd10, 5'd9,  32'h12, 32'h99, 5'd9,  32'h99,       5'd10, 32'hFFFFFFFF, 64'd6,  1'b1};
    tbl[4] = '{2'b11, 2'b00, 5'd11, 5'd13, 32'h1,  32'h2,  5'd11, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF, 64'd8,  1'b1};
    tbl[5] = '{2'b11, 2'b01, 5'd12, 5'd12, 32'h34, 32'h56, 5'd12, 32'h34,       5'd6,  32'h22,       64'd10, 1'b1};

    rst_n = 1'b0;
    m_reset();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset x2", {32'h0, regfile[2*32 +: 32]}, 64'h00007500);
    check("reset x5", {32'h0, regfile[5*32 +: 32]}, 64'hFFFFFFFF);
    check("reset x0", {32'h0, regfile[0 +: 32]}, 64'h0);
    check("reset inst_count", inst_count, 64'd0);
    check("reset clock_count", clock_count, 64'd0);
    check_all("reset");
    #2 rst_n = 1'b1;
    step();
    check("first clock_count", clock_count, 64'd1);
    check_all("idle");

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      step();
      check($sformatf("vec%0d reg%0d", i, tbl[i].r1), {32'h0, regfile[tbl[i].r1*32 +: 32]}, {32'h0, tbl[i].e1});
      check($sformatf("vec%0d reg%0d", i, tbl[i].r2), {32'h0, regfile[tbl[i].r2*32 +: 32]}, {32'h0, tbl[i].e2});
      check($sformatf("vec%0d inst_count", i), inst_count, tbl[i].eic);
      check($sformatf("vec%0d halt", i), {63'd0, halt}, {63'd0, tbl[i].eh});
      check_all($sformatf("vec%0d", i));
    end

    // Asynchronous reset between clock edges.
    drive(2'b11, 2'b11, 5'd20, 5'd21, 32'hDEAD, 32'hBEEF);
    step();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("async x7", {32'h0, regfile[7*32 +: 32]}, 64'hFFFFFFFF);
    check("async x2", {32'h0, regfile[2*32 +: 32]}, 64'h00007500);
    check("async inst_count", inst_count, 64'd0);
    check("async clock_count", clock_count, 64'd0);
    check("async halt", {63'd0, halt}, 64'd0);
    check_all("async");
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Halt steps over the limit on a dual retire, then holds while retiring continues.
    for (int i = 0; i < 4; i++) begin
      drive((i == 3) ? 2'b01 : 2'b11, 2'b11, 5'(i + 1), 5'(i + 14), 32'(i * 3), 32'(i * 7));
      step();
      check($sformatf("halt seq%0d halt", i), {63'd0, halt}, (i >= 2) ? 64'd1 : 64'd0);
      check($sformatf("halt seq%0d inst_count", i), inst_count, (i == 3) ? 64'd7 : 64'(2 * (i + 1)));
      check_all($sformatf("halt seq%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      logic [4:0] a0;
      a0 = 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a0,
            ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31)), $urandom, $urandom);
      step();
      check_all($sformatf("rand%0d", i));
    end

`ifdef WB_INSTID_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      valid = 2'b11; rf_wen = 2'b00;
      inst_id = {8'd1, 8'd0};
      @(posedge clk); #1;
      inst_id = (k == 0) ? {8'd3, 8'd2} : {8'd4, 8'd2};
      @(posedge clk); #1;
      check($sformatf("order case%0d", k), {63'd0, order_err}, (k == 0) ? 64'd0 : 64'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
